// File: rtl/mlp_seq_pkg.sv
// Shared types and constants for the multi-layer MLP sequencer.
// Byte order within a layer's 4-byte weight slot is W10, W00, W11, W01.
package mlp_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET_FIFO,
        PUSH,
        KICK,
        WAIT_DONE,
        CAPTURE,
        ERROR
    } seq_state_t;

    localparam int BYTES_PER_LAYER = 4;

    localparam logic [1:0] K_W10 = 2'd0;
    localparam logic [1:0] K_W00 = 2'd1;
    localparam logic [1:0] K_W11 = 2'd2;
    localparam logic [1:0] K_W01 = 2'd3;

endpackage

// File: rtl/mlp_weight_store.sv
// Weight byte register file: synchronous write, combinational read, cleared on reset.
// Writes to addresses at or beyond DEPTH are dropped; such reads return 0.
module mlp_weight_store #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'd0;
            end
        end else if (we && ({1'b0, waddr} < DEPTH_V)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < DEPTH_V) ? mem[raddr] : 8'd0;

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Streams per-layer weights into the mlp_top FIFO and kicks each layer; start->start_mlp is 6 cycles,
// layer_complete edge->weights_ready is 5 cycles. No backpressure: waits on layer_complete rising edges with a timeout.
module mlp_layer_sequencer
    import mlp_seq_pkg::*;
#(
    parameter int MAX_LAYERS     = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          cfg_we,
    input  logic [$clog2(BYTES_PER_LAYER*MAX_LAYERS)-1:0] cfg_addr,
    input  logic [7:0]                                    cfg_wdata,
    input  logic [$clog2(MAX_LAYERS+1)-1:0]               num_layers,
    input  logic                                          seq_start,
    input  logic                                          seq_abort,
    output logic                                          seq_busy,
    output logic                                          seq_done,
    output logic                                          seq_error,
    output logic [$clog2(MAX_LAYERS)-1:0]                 cur_layer,
    output logic                                          wf_push_col0,
    output logic                                          wf_push_col1,
    output logic [7:0]                                    wf_data_in,
    output logic                                          wf_reset,
    output logic                                          start_mlp,
    output logic                                          weights_ready,
    input  logic                                          layer_complete,
    input  logic signed [31:0]                            acc0,
    input  logic signed [31:0]                            acc1,
    output logic signed [31:0]                            res_acc0,
    output logic signed [31:0]                            res_acc1
);

    localparam int AW = $clog2(BYTES_PER_LAYER * MAX_LAYERS);
    localparam int LW = $clog2(MAX_LAYERS);
    localparam int NW = $clog2(MAX_LAYERS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [NW-1:0] NL_MAX   = NW'(MAX_LAYERS);

    seq_state_t    state, state_n;
    logic [1:0]    k, k_n;
    logic [LW-1:0] layer_n;
    logic [NW-1:0] nl_q, nl_n;
    logic [TW-1:0] tmo, tmo_n;
    logic          lc_prev;
    logic          lc_rise;
    logic          last_layer;
    logic          bad_start;
    logic [7:0]    rd_byte;
    logic [AW-1:0] rd_addr;

    // Read address follows the next-state layer/byte so the registered push data lines up with the push strobe.
    assign rd_addr    = {layer_n, k_n};
    assign lc_rise    = layer_complete && !lc_prev;
    assign last_layer = ((NW'(cur_layer) + NW'(1)) == nl_q);

    mlp_weight_store #(
        .DEPTH(BYTES_PER_LAYER * MAX_LAYERS),
        .AW   (AW)
    ) u_store (
        .clk  (clk),
        .rst  (rst),
        .we   (cfg_we && (state == IDLE)),
        .waddr(cfg_addr),
        .wdata(cfg_wdata),
        .raddr(rd_addr),
        .rdata(rd_byte)
    );

    always_comb begin
        state_n   = state;
        k_n       = k;
        layer_n   = cur_layer;
        nl_n      = nl_q;
        tmo_n     = tmo;
        bad_start = 1'b0;
        case (state)
            IDLE: begin
                if (seq_start) begin
                    if ((num_layers != '0) && (num_layers <= NL_MAX)) begin
                        nl_n    = num_layers;
                        layer_n = '0;
                        state_n = RESET_FIFO;
                    end else begin
                        bad_start = 1'b1;
                    end
                end
            end
            RESET_FIFO: begin
                k_n     = K_W10;
                state_n = PUSH;
            end
            PUSH: begin
                k_n = k + 2'd1;
                if (k == K_W01) begin
                    state_n = KICK;
                end
            end
            KICK: begin
                tmo_n   = '0;
                state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (lc_rise) begin
                    if (last_layer) begin
                        state_n = CAPTURE;
                    end else begin
                        layer_n = cur_layer + LW'(1);
                        k_n     = K_W10;
                        state_n = PUSH;
                    end
                end else if (tmo == TMO_LAST) begin
                    state_n = ERROR;
                end else begin
                    tmo_n = tmo + TW'(1);
                end
            end
            CAPTURE: state_n = IDLE;
            ERROR:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (seq_abort && (state != IDLE)) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            cur_layer <= '0;
            nl_q      <= '0;
            tmo       <= '0;
            lc_prev   <= 1'b0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            cur_layer <= layer_n;
            nl_q      <= nl_n;
            tmo       <= tmo_n;
            lc_prev   <= layer_complete;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wf_reset      <= 1'b0;
            wf_push_col0  <= 1'b0;
            wf_push_col1  <= 1'b0;
            wf_data_in    <= 8'd0;
            start_mlp     <= 1'b0;
            weights_ready <= 1'b0;
            seq_busy      <= 1'b0;
            seq_done      <= 1'b0;
            seq_error     <= 1'b0;
            res_acc0      <= '0;
            res_acc1      <= '0;
        end else begin
            wf_reset      <= (state_n == RESET_FIFO);
            wf_push_col0  <= (state_n == PUSH) && (k_n < K_W11);
            wf_push_col1  <= (state_n == PUSH) && (k_n >= K_W11);
            wf_data_in    <= (state_n == PUSH) ? rd_byte : 8'd0;
            start_mlp     <= (state_n == KICK) && (layer_n == '0);
            weights_ready <= (state_n == KICK) && (layer_n != '0);
            seq_busy      <= (state_n != IDLE);
            seq_done      <= (state_n == CAPTURE);
            seq_error     <= (state_n == ERROR) || bad_start;
            if ((state == WAIT_DONE) && (state_n == CAPTURE)) begin
                res_acc0 <= acc0;
                res_acc1 <= acc1;
            end
        end
    end

endmodule

// File: doc/mlp_layer_sequencer.md
# mlp_layer_sequencer

Autonomous multi-layer inference sequencer placed between the host command path and `mlp_top`. Holds weights for up to `MAX_LAYERS` layers in an internal byte store. On one start pulse it:
- resets the weight FIFO, streams layer 0 weights and pulses `start_mlp`;
- for each later layer, streams its weights and pulses `weights_ready`, waiting for `layer_complete` between layers;
- captures the final accumulators.

This removes per-layer host round-trips over UART.

## Interface
- `MAX_LAYERS`, 4: weight-store depth in layers (4 bytes per layer).
- `TIMEOUT_CYCLES`, 1_000_000: maximum cycles spent in WAIT_DONE before error.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_we`  in  1  write one weight byte into the store.
- `cfg_addr`  in  $clog2(4*MAX_LAYERS)  byte address = layer*4 + k; k order is W10, W00, W11, W01.
- `cfg_wdata`  in  8  weight byte.
- `num_layers`  in  $clog2(MAX_LAYERS+1)  layer count, sampled on accepted `seq_start`.
- `seq_start`  in  1  start pulse.
- `seq_abort`  in  1  abort pulse.
- `seq_busy`  out  1  high from the cycle after accept until return to IDLE.
- `seq_done`  out  1  one-cycle pulse on successful completion.
- `seq_error`  out  1  one-cycle pulse on bad `num_layers` or timeout.
- `cur_layer`  out  $clog2(MAX_LAYERS)  index of the layer in progress.
- `wf_push_col0`, `wf_push_col1`  out  1  weight FIFO push pulses.
- `wf_data_in`  out  8  weight byte, valid with a push.
- `wf_reset`  out  1  FIFO reset pulse.
- `start_mlp`, `weights_ready`  out  1  `mlp_top` control pulses.
- `layer_complete`  in  1  level from `mlp_top`.
- `acc0`, `acc1`  in  32 signed  accumulators.
- `res_acc0`, `res_acc1`  out  32 signed  captured final results; hold until the next capture.

## Operation
- **States:** IDLE, RESET_FIFO, PUSH, KICK, WAIT_DONE, CAPTURE, ERROR.
- **IDLE**
  - `seq_start` with 1 ≤ `num_layers` ≤ MAX_LAYERS: latch `num_layers`, set `cur_layer`=0, go to RESET_FIFO.
  - `seq_start` with any other `num_layers`: `seq_error` pulse next cycle, stay in IDLE.
- **RESET_FIFO:** `wf_reset`=1 for one cycle, then PUSH. The FIFO is reset only at sequence start, never between layers.
- **PUSH:** four consecutive cycles, byte counter k=0..3.
  - `wf_data_in` = store[`cur_layer`*4+k].
  - `wf_push_col0` for k=0,1; `wf_push_col1` for k=2,3.
  - Then KICK.
- **KICK:** one cycle.
  - `start_mlp`=1 if `cur_layer`==0, else `weights_ready`=1.
  - Clear the timeout counter and go to WAIT_DONE.
- **WAIT_DONE:** wait for a rising edge of `layer_complete`, detected against its previous-cycle value.
  - Edge on a non-final layer: increment `cur_layer`, go to PUSH.
  - Edge on the final layer: go to CAPTURE.
  - Counter reaches TIMEOUT_CYCLES-1 with no edge: go to ERROR.
- **CAPTURE:** register `acc0`/`acc1` into `res_acc0`/`res_acc1`, pulse `seq_done`, go to IDLE.
- **ERROR:** pulse `seq_error`, go to IDLE. `res_*` are unchanged.
- **`seq_abort`:** in any non-IDLE state, go to IDLE next cycle.
  - All pulse outputs are 0 that cycle.
  - No `seq_done` or `seq_error`.
  - Abort has priority over every other transition.
- **`cfg_we`:** honoured only in IDLE; ignored while `seq_busy`.
  - `cfg_addr` ≥ 4*MAX_LAYERS is ignored.
  - `cfg_we` together with `seq_start` in IDLE: the write lands first; the sequence uses the new byte.
- **`seq_start` while busy:** ignored.

## Timing
- All outputs are registered.
- **Reset values:** every pulse output 0, `wf_data_in`=0, `seq_busy`=0, `cur_layer`=0, `res_acc0`=`res_acc1`=0. The weight store is cleared to 0.
- **Start latency:** `seq_start` accepted at cycle T gives:
  - `wf_reset` at T+1;
  - pushes at T+2..T+5;
  - `start_mlp` at T+6;
  - `seq_busy` high from T+1.
- **Layer turnaround:** `layer_complete` edge seen at cycle E gives pushes at E+1..E+4 and `weights_ready` at E+5.
- **Completion:** final edge at E gives `res_*` updated and `seq_done`=1 at E+1, and `seq_busy`=0 at E+2.
- `layer_complete` already high on entry to WAIT_DONE does not count; a new rising edge is required.
- Reset mid-sequence returns immediately to reset values; the FIFO is not explicitly reset.

## Structure
- **Package `mlp_seq_pkg`:**
  - state enum `seq_state_t`;
  - byte-order constants `K_W10`=0, `K_W00`=1, `K_W11`=2, `K_W01`=3;
  - `BYTES_PER_LAYER`=4.
- **Sub-module `mlp_weight_store`:** synchronous-write, asynchronous-read byte register file, sized 4*MAX_LAYERS. It has its own reset clear.
- The FSM, byte counter, timeout counter and edge detector live in `mlp_layer_sequencer`.

## Test plan
- **Single layer:** load bytes 0x10,0x20,0x30,0x40 at addresses 0..3, `num_layers`=1, start at T.
  - `wf_reset` at T+1.
  - col0 pushes 0x10,0x20 and col1 pushes 0x30,0x40 at T+2..T+5.
  - `start_mlp` at T+6.
  - Drive `layer_complete` with `acc0`=5, `acc1`=-7 → `res_acc0`=5, `res_acc1`=-7 and `seq_done` one cycle later.
- **Three layers:** each `layer_complete` edge → next four pushes from addresses 4..7 then 8..11, each followed by `weights_ready`.
  - No further `wf_reset`.
  - `start_mlp` exactly once.
  - `seq_done` after the third edge only.
- **Bad count:** `num_layers`=0, then MAX_LAYERS+1 → `seq_error` pulse each time, `seq_busy` stays 0, no FIFO activity.
- **Timeout:** TIMEOUT_CYCLES=16 with `layer_complete` held low → `seq_error` 16–17 cycles after KICK; `res_*` unchanged.
- **Abort and busy rules:**
  - `seq_abort` during PUSH → no further pushes; IDLE next cycle.
  - `cfg_we` while busy leaves the store unchanged.
  - `layer_complete` held high across KICK does not advance the sequence.
- **Async reset** asserted mid-WAIT_DONE → all outputs return to reset values without waiting for a clock edge.
